// File: rtl/seq_pkg.sv
// Shared types and constants for the stage sequencer.
package seq_pkg;

    localparam int SEQ_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/stage_sequencer.sv
// Launches STAGES stages one after another, waiting for each ready (or timeout).
// Optional timeout/error logic is built only when SEQ_TIMEOUT_EN is defined.
module stage_sequencer
    import seq_pkg::*;
#(
    parameter int                STAGES     = 3,
    parameter int                TMO_CYCLES = 32768,
    parameter logic [STAGES-1:0] TMO_MASK   = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_start_in,
    input  logic              abort_in,
    input  logic [STAGES-1:0] stage_rdy_in,
    output logic [STAGES-1:0] stage_start_out,
    output logic              rdy_out,
    output logic              done_out,
    output logic              err_out,
    output logic [3:0]        err_stage_out
);

    localparam logic [SEQ_IDX_W-1:0] LAST_IDX = SEQ_IDX_W'(STAGES - 1);

    generate
        if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
            $error("stage_sequencer: STAGES must be in 1..16");
        end
        if (TMO_CYCLES < 2 || TMO_CYCLES > 65536) begin : g_bad_tmo
            $error("stage_sequencer: TMO_CYCLES must be in 2..65536");
        end
        if ($bits(TMO_MASK) != STAGES) begin : g_bad_mask
            $error("stage_sequencer: TMO_MASK must be STAGES bits wide");
        end
    endgenerate

    seq_state_e            r_state;
    seq_state_e            w_state_nxt;
    logic [SEQ_IDX_W-1:0]  r_idx;
    logic                  r_host_q;
    logic                  r_rst_q;
    logic [STAGES-1:0]     r_start;
    logic                  r_done;

    logic [STAGES-1:0]     w_onehot;
    logic [STAGES-1:0]     w_start_nxt;
    logic                  w_done_nxt;
    logic                  w_idx_inc;
    logic                  w_rdy_sel;
    logic                  w_edge;
    logic                  w_go;
    logic                  w_accept;
    logic                  w_tmo;
    logic                  w_adv;
    logic                  w_last;

    // Ready is only honoured once the start pulse for that stage has dropped.
    always_comb begin
        w_onehot  = '0;
        w_rdy_sel = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_onehot[k] = (r_idx == SEQ_IDX_W'(k));
            w_rdy_sel   = w_rdy_sel | (w_onehot[k] & stage_rdy_in[k] & ~r_start[k]);
        end
    end

    // r_rst_q masks the first cycle after reset so a level held through release is not an edge.
    assign w_edge   = host_start_in & ~r_host_q & ~r_rst_q;
    assign w_go     = (r_state == ST_IDLE) && w_edge && !abort_in;
    assign w_accept = (r_state == ST_WAIT) && w_rdy_sel;
    assign w_adv    = w_accept | w_tmo;
    assign w_last   = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_go) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_adv) w_state_nxt = w_last ? ST_DONE : ST_RUN;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (abort_in) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_start_nxt = '0;
        w_done_nxt  = 1'b0;
        w_idx_inc   = 1'b0;
        if (!abort_in) begin
            if (r_state == ST_RUN)  w_start_nxt = w_onehot;
            if (r_state == ST_DONE) w_done_nxt  = 1'b1;
            if (r_state == ST_WAIT && w_adv && !w_last) w_idx_inc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= '0;
            r_host_q <= 1'b0;
            r_rst_q  <= 1'b1;
            r_start  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_host_q <= host_start_in;
            r_rst_q  <= 1'b0;
            r_start  <= w_start_nxt;
            r_done   <= w_done_nxt;
            if (w_go) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + SEQ_IDX_W'(1);
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

    logic [15:0] r_cnt;
    logic        r_err;
    logic [3:0]  r_err_stage;
    logic        w_mask_sel;

    assign w_mask_sel = |(w_onehot & TMO_MASK);
    // A ready arriving on the timeout cycle wins, so no error is flagged then.
    assign w_tmo      = (r_state == ST_WAIT) && !w_rdy_sel && w_mask_sel && (r_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_err_stage <= '0;
        end else begin
            if (r_state == ST_RUN) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_go) begin
                r_err       <= 1'b0;
                r_err_stage <= '0;
            end else if (w_tmo && !abort_in) begin
                r_err <= 1'b1;
                if (!r_err) r_err_stage <= r_idx;
            end
        end
    end

    assign err_out       = r_err;
    assign err_stage_out = r_err_stage;
`else
    assign w_tmo         = 1'b0;
    assign err_out       = 1'b0;
    assign err_stage_out = 4'd0;
`endif

    assign stage_start_out = r_start;
    assign done_out        = r_done;
    assign rdy_out         = (r_state == ST_IDLE);

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: run-level reference model plus directed and random stimulus.
module tb_stage_sequencer;

    localparam int         STAGES     = 3;
    localparam int         TMO_CYCLES = 16;
    localparam logic [2:0] TMO_MASK   = 3'b101;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       host;
    logic       abort;
    logic [2:0] rdy;
    logic [2:0] start_out;
    logic       rdy_out;
    logic       done_out;
    logic       err_out;
    logic [3:0] err_stage_out;

    stage_sequencer #(
        .STAGES    (STAGES),
        .TMO_CYCLES(TMO_CYCLES),
        .TMO_MASK  (TMO_MASK)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .host_start_in  (host),
        .abort_in       (abort),
        .stage_rdy_in   (rdy),
        .stage_start_out(start_out),
        .rdy_out        (rdy_out),
        .done_out       (done_out),
        .err_out        (err_out),
        .err_stage_out  (err_stage_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Run-level model: a run is a list of stages, each taking a launch cycle,
    // a pulse cycle, then waiting; one finishing cycle, then done is seen.
    bit         m_busy      = 1'b0;
    bit         m_done      = 1'b0;
    bit         m_err       = 1'b0;
    bit         m_prev_host = 1'b0;
    bit         m_just_rst  = 1'b1;
    int         m_stage     = 0;
    int         m_age       = 0;
    logic [3:0] m_es        = 4'd0;

    // Stage responder: mode 0 never, 1 ready dly cycles after its pulse, 2 always, 3 random
    int mode[3];
    int dly[3];
    int since[3];

    int n_done    = 0;
    int last_done = -1;
    int pq_cyc[$];
    int pq_val[$];

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        bit edge_s, ready_ok, tmo, done_nxt;
        if (reset) begin
            m_busy = 0; m_done = 0; m_err = 0; m_es = 4'd0;
            m_prev_host = 0; m_just_rst = 1;
            return;
        end
        edge_s      = host && !m_prev_host && !m_just_rst;
        m_prev_host = host;
        m_just_rst  = 0;
        done_nxt    = m_busy && (m_stage == STAGES) && !abort;
        if (!m_busy) begin
            if (edge_s && !abort) begin
                m_busy = 1; m_stage = 0; m_age = 0; m_err = 0; m_es = 4'd0;
            end
        end else if (abort || m_stage == STAGES) begin
            m_busy = 0;
        end else begin
            ready_ok = (m_age >= 2) && rdy[m_stage];
            tmo      = TMO_EN && !ready_ok && TMO_MASK[m_stage] && (m_age == TMO_CYCLES);
            if (ready_ok || tmo) begin
                if (tmo) begin
                    if (!m_err) m_es = 4'(m_stage);
                    m_err = 1;
                end
                m_stage++;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
        m_done = done_nxt;
    endtask

    task automatic check();
        int exp_start;
        exp_start = (m_busy && m_stage < STAGES && m_age == 1) ? (1 << m_stage) : 0;
        cmp("rdy_out", int'(rdy_out), int'(!m_busy));
        cmp("stage_start_out", int'(start_out), exp_start);
        cmp("done_out", int'(done_out), int'(m_done));
        cmp("err_out", int'(err_out), int'(m_err));
        cmp("err_stage_out", int'(err_stage_out), int'(m_es));
        if (done_out) begin
            n_done++;
            last_done = cyc;
        end
        if (start_out != 3'd0) begin
            pq_cyc.push_back(cyc);
            pq_val.push_back(int'(start_out));
        end
    endtask

    task automatic respond();
        for (int k = 0; k < 3; k++) begin
            if (start_out[k]) since[k] = 0;
            else if (since[k] >= 0 && since[k] < 100000) since[k]++;
            case (mode[k])
                0:       rdy[k] = 1'b0;
                1:       rdy[k] = (since[k] >= 0) && (since[k] >= dly[k]);
                2:       rdy[k] = 1'b1;
                default: rdy[k] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        check();
        respond();
    endtask

    task automatic set_modes(input int a, input int b, input int c, input int d);
        mode[0] = a; mode[1] = b; mode[2] = c;
        for (int k = 0; k < 3; k++) begin
            dly[k]   = d;
            since[k] = -1;
        end
        respond();
    endtask

    // Force idle via abort and clear the event logs.
    task automatic prep();
        host  = 1'b0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        cycle();
        cycle();
        n_done    = 0;
        last_done = -1;
        pq_cyc.delete();
        pq_val.delete();
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && n_done == 0; i++) cycle();
    endtask

    task automatic check_pulses(input string tag, input int t0, input int o0, input int o1, input int o2);
        cmp({tag, "_npulse"}, pq_cyc.size(), 3);
        if (pq_cyc.size() == 3) begin
            cmp({tag, "_p0_cyc"}, pq_cyc[0] - t0, o0);
            cmp({tag, "_p1_cyc"}, pq_cyc[1] - t0, o1);
            cmp({tag, "_p2_cyc"}, pq_cyc[2] - t0, o2);
            cmp({tag, "_p0_val"}, pq_val[0], 1);
            cmp({tag, "_p1_val"}, pq_val[1], 2);
            cmp({tag, "_p2_val"}, pq_val[2], 4);
        end
    endtask

    initial begin
        int t0;
        int t1;
        reset = 1'b1;
        host  = 1'b0;
        abort = 1'b0;
        rdy   = 3'b000;
        set_modes(1, 1, 1, 3);
        repeat (3) cycle();
        cmp("RST_rdy", int'(rdy_out), 1);
        cmp("RST_start", int'(start_out), 0);
        cmp("RST_done", int'(done_out), 0);
        cmp("RST_err", int'(err_out), 0);
        reset = 1'b0;
        cycle();

        // Ready returned 3 cycles after each start
        set_modes(1, 1, 1, 3);
        prep();
        t0 = cyc; host = 1'b1; cycle(); host = 1'b0;
        wait_done(60);
        cmp("A_done_lat", last_done - t0, 17);
        check_pulses("A", t0, 2, 7, 12);
        repeat (3) cycle();
        cmp("A_ndone", n_done, 1);
        cmp("A_err", int'(err_out), 0);

        // Ready held high permanently
        set_modes(2, 2, 2, 0);
        prep();
        t0 = cyc; host = 1'b1; cycle(); host = 1'b0;
        wait_done(60);
        cmp("B_done_lat", last_done - t0, 11);
        check_pulses("B", t0, 2, 5, 8);

        // Stage 0 never ready
        set_modes(0, 1, 1, 3);
        prep();
        t0 = cyc; host = 1'b1; cycle(); host = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        wait_done(80);
        cmp("C_done_lat", last_done - t0, 29);
        check_pulses("C", t0, 2, 19, 24);
        cmp("C_err", int'(err_out), 1);
        cmp("C_err_stage", int'(err_stage_out), 0);
`else
        repeat (40) cycle();
        cmp("C_ndone", n_done, 0);
        cmp("C_npulse", pq_cyc.size(), 1);
        cmp("C_busy", int'(rdy_out), 0);
        cmp("C_err", int'(err_out), 0);
`endif

        // Stage 1 never ready and not allowed to time out, then abort
        set_modes(1, 0, 1, 3);
        prep();
        t0 = cyc; host = 1'b1; cycle(); host = 1'b0;
        while (cyc < t0 + 107) cycle();
        cmp("D_busy", int'(rdy_out), 0);
        cmp("D_npulse", pq_cyc.size(), 2);
        cmp("D_err", int'(err_out), 0);
        abort = 1'b1; cycle(); abort = 1'b0;
        cmp("D_rdy_after_abort", int'(rdy_out), 1);
        repeat (10) cycle();
        cmp("D_ndone", n_done, 0);

        // Extra edge during WAIT ignored; held level after done does not restart
        set_modes(1, 1, 1, 3);
        prep();
        t0 = cyc; host = 1'b1; cycle(); host = 1'b0;
        while (cyc < t0 + 4) cycle();
        host = 1'b1;
        wait_done(60);
        cmp("E_done_lat", last_done - t0, 17);
        repeat (10) cycle();
        cmp("E_idle_held", int'(rdy_out), 1);
        cmp("E_npulse", pq_cyc.size(), 3);
        cmp("E_ndone", n_done, 1);
        host = 1'b0; cycle();
        t1 = cyc; host = 1'b1; cycle(); cycle();
        cmp("E_restart_npulse", pq_cyc.size(), 4);
        if (pq_cyc.size() == 4) cmp("E_restart_cyc", pq_cyc[3] - t1, 2);

        // Reset during WAIT of stage 1 with host high across release
        set_modes(1, 0, 1, 3);
        prep();
        t0 = cyc; host = 1'b1; cycle(); host = 1'b0;
        while (cyc < t0 + 9) cycle();
        reset = 1'b1; host = 1'b1; cycle();
        cmp("F_rdy", int'(rdy_out), 1);
        cmp("F_start", int'(start_out), 0);
        cmp("F_done", int'(done_out), 0);
        cmp("F_err", int'(err_out), 0);
        cycle();
        reset = 1'b0;
        repeat (10) cycle();
        cmp("F_no_start_rdy", int'(rdy_out), 1);
        cmp("F_no_start_npulse", pq_cyc.size(), 2);
        host = 1'b0;

        // Randomized traffic
        prep();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                for (int k = 0; k < 3; k++) begin
                    mode[k] = int'($urandom_range(0, 3));
                    dly[k]  = int'($urandom_range(0, 6));
                end
            end
            if ($urandom_range(0, 7) == 0) host = ~host;
            abort = ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;
        abort = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
